// File: rtl/risc_pkg.sv
// Shared encodings for the RISC datapath: ALU opcodes, bus_2 selects, flag bit positions.
package risc_pkg;
  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3, OP_OR  = 4'd4,
    OP_XOR = 4'd5, OP_NOT = 4'd6, OP_SHL = 4'd7, OP_SHR = 4'd8
  } opcode_e;

  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;
  localparam logic [1:0] SEL2_TOP  = 2'd3;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/risc_datapath_if.sv
// Control strobes, memory data and status outputs of the RISC datapath.
interface risc_datapath_if #(parameter int WORD_W = 8, parameter int NUM_REGS = 4);
  localparam int SEL1_W = $clog2(NUM_REGS + 1);

  logic [WORD_W-1:0]   mem_word;
  logic [NUM_REGS-1:0] load_reg;
  logic                load_ir, load_add_r, load_reg_y, load_pc, inc_pc, load_flags, push_pc, pop_pc;
  logic [SEL1_W-1:0]   sel_bus_1;
  logic [1:0]          sel_bus_2;
  logic [WORD_W-1:0]   bus_1, address, instruction;
  logic [3:0]          flags;
  logic                stack_full, stack_empty, stack_err;

  modport master (
    output mem_word, load_reg, load_ir, load_add_r, load_reg_y, load_pc, inc_pc, load_flags,
           push_pc, pop_pc, sel_bus_1, sel_bus_2,
    input  bus_1, address, instruction, flags, stack_full, stack_empty, stack_err
  );
  modport slave (
    input  mem_word, load_reg, load_ir, load_add_r, load_reg_y, load_pc, inc_pc, load_flags,
           push_pc, pop_pc, sel_bus_1, sel_bus_2,
    output bus_1, address, instruction, flags, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/risc_alu.sv
// Combinational ALU; flags packed as {N,Z,C,V}.
module risc_alu import risc_pkg::*; #(
  parameter int WORD_W = 8
) (
  input  logic [3:0]        opcode,
  input  logic [WORD_W-1:0] data_1,
  input  logic [WORD_W-1:0] data_2,
  output logic [WORD_W-1:0] alu_out,
  output logic [3:0]        alu_flags
);
  localparam int M = WORD_W - 1;
  logic c, v;

  always_comb begin
    alu_out = '0;
    c       = 1'b0;
    v       = 1'b0;
    case (opcode)
      OP_ADD: begin
        {c, alu_out} = {1'b0, data_1} + {1'b0, data_2};
        v = (data_1[M] == data_2[M]) && (alu_out[M] != data_1[M]);
      end
      OP_SUB: begin
        alu_out = data_1 - data_2;
        c = data_1 < data_2;
        v = (data_1[M] != data_2[M]) && (alu_out[M] != data_1[M]);
      end
      OP_AND: alu_out = data_1 & data_2;
      OP_OR:  alu_out = data_1 | data_2;
      OP_XOR: alu_out = data_1 ^ data_2;
      OP_NOT: alu_out = ~data_2;
      OP_SHL: begin alu_out = {data_2[M-1:0], 1'b0}; c = data_2[M]; end
      OP_SHR: begin alu_out = {1'b0, data_2[M:1]};   c = data_2[0]; end
      default: ;
    endcase
  end

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_out[M];
    alu_flags[FLAG_Z] = (alu_out == '0);
    alu_flags[FLAG_C] = c;
    alu_flags[FLAG_V] = v;
  end
endmodule

// File: rtl/risc_datapath.sv
// RISC datapath: register file, Y/IR/ADD_R, PC with return-address stack, two buses and ALU.
module risc_datapath import risc_pkg::*; #(
  parameter int WORD_W      = 8,
  parameter int NUM_REGS    = 4,
  parameter int STACK_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  risc_datapath_if.slave  dp
);
  localparam int SEL1_W = $clog2(NUM_REGS + 1);
  localparam int PTR_W  = $clog2(STACK_DEPTH);
  localparam int DEP_W  = PTR_W + 1;

  logic [NUM_REGS-1:0][WORD_W-1:0]    regs;
  logic [STACK_DEPTH-1:0][WORD_W-1:0] stack;
  logic [WORD_W-1:0] pc, pc_inc, y, ir, add_r, bus_1, bus_2, alu_out, top;
  logic [3:0]        alu_flags, flags;
  logic [DEP_W-1:0]  depth;
  logic [PTR_W-1:0]  top_ptr;
  logic              empty, full, pop_ok, push_ok, err;

  assign pc_inc  = pc + 1'b1;
  assign empty   = (depth == '0);
  assign full    = (depth == DEP_W'(STACK_DEPTH));
  assign top_ptr = PTR_W'(depth - 1'b1);
  assign top     = empty ? '0 : stack[top_ptr];
  assign pop_ok  = dp.pop_pc && !empty;
  // A simultaneous valid pop frees the top slot, so push is allowed even when full.
  assign push_ok = dp.push_pc && (!full || pop_ok);

  always_comb begin
    bus_1 = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (dp.sel_bus_1 == SEL1_W'(i)) bus_1 = regs[i];
    if (dp.sel_bus_1 == SEL1_W'(NUM_REGS)) bus_1 = pc;
  end

  always_comb begin
    case (dp.sel_bus_2)
      SEL2_ALU:  bus_2 = alu_out;
      SEL2_BUS1: bus_2 = bus_1;
      SEL2_MEM:  bus_2 = dp.mem_word;
      default:   bus_2 = top;
    endcase
  end

  risc_alu #(.WORD_W(WORD_W)) u_alu (
    .opcode(ir[WORD_W-1:WORD_W-4]), .data_1(y), .data_2(bus_1),
    .alu_out(alu_out), .alu_flags(alu_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs  <= '0;
      y     <= '0;
      ir    <= '0;
      add_r <= '0;
      flags <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (dp.load_reg[i]) regs[i] <= bus_2;
      if (dp.load_reg_y) y     <= bus_2;
      if (dp.load_ir)    ir    <= bus_2;
      if (dp.load_add_r) add_r <= bus_2;
      if (dp.load_flags) flags <= alu_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      depth <= '0;
      err   <= 1'b0;
    end else begin
      if (pop_ok)          pc <= top;
      else if (dp.load_pc) pc <= bus_2;
      else if (dp.inc_pc)  pc <= pc_inc;
      if (push_ok && !pop_ok)      depth <= depth + 1'b1;
      else if (pop_ok && !push_ok) depth <= depth - 1'b1;
      if ((dp.push_pc && !push_ok) || (dp.pop_pc && !pop_ok)) err <= 1'b1;
    end
  end

  // Entries are not reset; depth alone defines what is valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_ok && pop_ok) stack[top_ptr]           <= pc_inc;
      else if (push_ok)      stack[depth[PTR_W-1:0]]  <= pc_inc;
    end
  end

  assign dp.bus_1       = bus_1;
  assign dp.address     = add_r;
  assign dp.instruction = ir;
  assign dp.flags       = flags;
  assign dp.stack_full  = full;
  assign dp.stack_empty = empty;
  assign dp.stack_err   = err;
endmodule
